// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// State encoding, grant ids and parameter defaults live here.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      XFER_IF = 2'd1,
      XFER_DM = 2'd2
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } grant_t;

   localparam int          TIMEOUT_CYC_DEF = 255;
   localparam logic [31:0] ERR_RDATA_DEF   = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and shared memory port signals.
// slave = arbiter view, master = requesters plus memory view.
interface mem_port_arbiter_if;

   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;

   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   logic        busy;
   logic        err;

   modport slave (
      input  if_req, if_addr,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  mem_rdata, mem_ready,
      output if_ack, if_rdata,
      output dm_ack, dm_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output busy, err
   );

   modport master (
      output if_req, if_addr,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output mem_rdata, mem_ready,
      input  if_ack, if_rdata,
      input  dm_ack, dm_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  busy, err
   );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin chooser.
// req[0] = fetch, req[1] = data; gnt is one-hot or zero.
module rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  grant_t     last,
   output logic [1:0] gnt
);

   // On contention favour the requester that was not served last
   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last == GNT_DM) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// One transfer at a time, round-robin on contention, wait timeout abort.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

   state_t      state;
   grant_t      last_grant;
   logic [7:0]  wait_cnt;
   logic [7:0]  wait_nxt;
   logic [1:0]  elig;
   logic [1:0]  gnt;

   logic        mem_req_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic        if_ack_q;
   logic        dm_ack_q;
   logic [31:0] if_rdata_q;
   logic [31:0] dm_rdata_q;
   logic        busy_q;
   logic        err_q;

   // A requester whose ack is high this cycle cannot be re-granted
   assign elig[0] = bus.if_req & ~if_ack_q;
   assign elig[1] = bus.dm_req & ~dm_ack_q;
   assign wait_nxt = wait_cnt + 8'd1;

   rr_arb2 u_rr (
      .req  (elig),
      .last (last_grant),
      .gnt  (gnt)
   );

   // Transfer FSM with registered bus, ack and read-data outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= GNT_DM;
         wait_cnt    <= 8'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_rdata_q  <= 32'd0;
         dm_rdata_q  <= 32'd0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if_ack_q <= 1'b0;
         dm_ack_q <= 1'b0;
         err_q    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (gnt[0]) begin
                  state       <= XFER_IF;
                  last_grant  <= GNT_IF;
                  wait_cnt    <= 8'd0;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= bus.if_addr;
                  mem_wdata_q <= 32'd0;
                  busy_q      <= 1'b1;
               end else if (gnt[1]) begin
                  state       <= XFER_DM;
                  last_grant  <= GNT_DM;
                  wait_cnt    <= 8'd0;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= bus.dm_we;
                  mem_addr_q  <= bus.dm_addr;
                  mem_wdata_q <= bus.dm_wdata;
                  busy_q      <= 1'b1;
               end
            end
            XFER_IF, XFER_DM: begin
               if (bus.mem_ready || wait_nxt == TO_LIM) begin
                  state     <= IDLE;
                  mem_req_q <= 1'b0;
                  busy_q    <= 1'b0;
                  err_q     <= ~bus.mem_ready;
                  if (state == XFER_IF) begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= bus.mem_ready ? bus.mem_rdata
                                                 : ERR_RDATA;
                  end else begin
                     dm_ack_q <= 1'b1;
                     if (!mem_we_q)
                        dm_rdata_q <= bus.mem_ready ? bus.mem_rdata
                                                    : ERR_RDATA;
                  end
               end
               if (!bus.mem_ready)
                  wait_cnt <= wait_nxt;
            end
            default: begin
               state     <= IDLE;
               mem_req_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_ack    = dm_ack_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;

endmodule
